// File: rtl/rx_sequencer.sv
// Receive control unit for the UART receiver.
//
// Detects a start bit on the synchronized serial line, times each bit period and
// pulses shift_strobe at the centre of every bit (data bits plus stop bit). It then
// checks the captured stop bit and either loads the receive buffer or flags a
// framing error. It also tracks buffer occupancy and overrun.
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   serial_sync    synchronized serial line, idles high
//   stop_bit       MSB (stop bit) of the receive shift register
//   data_read      host consumed the buffered byte (1-cycle pulse)
//   shift_strobe   1-cycle pulse: shift register captures serial_sync
//   load_buffer    1-cycle pulse: copy packet data into the receive buffer
//   data_ready     buffer holds an unread byte
//   framing_error  last frame had stop bit == 0 (sticky until next start edge)
//   overrun_error  a byte was loaded while data_ready was still set
//   busy           sequencer is not idle
module rx_sequencer #(
  parameter int unsigned BIT_PERIOD = 10,
  parameter int unsigned NUM_BITS   = 9
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_sync,
  input  logic stop_bit,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  localparam int unsigned HALF   = BIT_PERIOD / 2;
  localparam int unsigned TimerW = $clog2(BIT_PERIOD);
  localparam int unsigned CntW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  // Timer value seen in the cycle where the start bit centre is sampled, and in
  // the cycle of each data/stop strobe.
  localparam logic [TimerW-1:0] HalfLast = TimerW'(HALF - 1);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(BIT_PERIOD - 1);
  localparam logic [CntW-1:0]   CntLast  = CntW'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStartChk,
    StReceive,
    StStopChk
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              prev_serial_q;
  logic              data_ready_q, data_ready_d;
  logic              framing_q, framing_d;
  logic              overrun_q, overrun_d;

  logic start_edge;
  logic bit_done;
  logic strobe;
  logic load;

  // Falling edge on the line, only honoured while idle.
  assign start_edge = (state_q == StIdle) && !serial_sync && prev_serial_q;
  assign bit_done   = (timer_q == BitLast);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) state_d = StStartChk;
      end
      StStartChk: begin
        if (timer_q == HalfLast) begin
          // Line back high at the start bit centre is a glitch, not a frame.
          state_d = serial_sync ? StIdle : StReceive;
        end
      end
      StReceive: begin
        if (bit_done && (bit_cnt_q == CntLast)) state_d = StStopChk;
      end
      StStopChk: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    strobe = 1'b0;
    load   = 1'b0;
    busy   = 1'b1;
    unique case (state_q)
      StIdle:     busy   = 1'b0;
      StStartChk: ;
      StReceive:  strobe = bit_done;
      StStopChk:  load   = stop_bit;
      default:    busy   = 1'b0;
    endcase
  end

  assign shift_strobe  = strobe;
  assign load_buffer   = load;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;

  // Bit timer and strobe counter; both held at zero outside the active states so
  // they are clear on entry to StStartChk.
  always_comb begin
    timer_d   = '0;
    bit_cnt_d = '0;
    unique case (state_q)
      StIdle: ;
      StStartChk: begin
        if (timer_q != HalfLast) timer_d = timer_q + TimerW'(1);
      end
      StReceive: begin
        bit_cnt_d = bit_cnt_q;
        if (bit_done) begin
          bit_cnt_d = (bit_cnt_q == CntLast) ? '0 : bit_cnt_q + CntW'(1);
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StStopChk: ;
      default: ;
    endcase
  end

  // Status flags
  always_comb begin
    framing_d = framing_q;
    if (start_edge) framing_d = 1'b0;
    if ((state_q == StStopChk) && !stop_bit) framing_d = 1'b1;

    // A load wins over a same-cycle read so the new byte is never lost.
    data_ready_d = data_ready_q;
    if (load) begin
      data_ready_d = 1'b1;
    end else if (data_read) begin
      data_ready_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (load && data_ready_q) begin
      overrun_d = 1'b1;
    end else if (data_read) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      prev_serial_q <= 1'b1;
      data_ready_q  <= 1'b0;
      framing_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      bit_cnt_q     <= bit_cnt_d;
      prev_serial_q <= serial_sync;
      data_ready_q  <= data_ready_d;
      framing_q     <= framing_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_rx_sequencer.sv
// Directed testbench for rx_sequencer. Instance a uses BIT_PERIOD=10, instance b
// uses BIT_PERIOD=16. Each instance feeds a small model of the 9-bit receive shift
// register so stop_bit and the captured byte come from the line as sent.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later, so
// each sample reflects the registered state and inputs of that clock cycle.
module tb_rx_sequencer;

  logic clk = 1'b0;
  logic n_rst, data_read, serial_a, serial_b;
  logic strobe_a, load_a, ready_a, fe_a, oe_a, busy_a;
  logic strobe_b, load_b, ready_b, fe_b, oe_b, busy_b;
  logic [8:0] sr_a = '0;
  logic [8:0] sr_b = '0;

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle observations of the most recent run_frame call (t = 0 is cycle E).
  logic obs_strobe [200];
  logic obs_load   [200];
  logic obs_ready  [200];
  logic obs_fe     [200];
  logic obs_oe     [200];
  logic obs_busy   [200];
  logic [7:0] obs_pkt;
  int n_loads;
  int n_strobes;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (strobe_a) sr_a <= {serial_a, sr_a[8:1]};
    if (strobe_b) sr_b <= {serial_b, sr_b[8:1]};
  end

  rx_sequencer #(.BIT_PERIOD(10), .NUM_BITS(9)) u_dut_a (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_sync   (serial_a),
    .stop_bit      (sr_a[8]),
    .data_read     (data_read),
    .shift_strobe  (strobe_a),
    .load_buffer   (load_a),
    .data_ready    (ready_a),
    .framing_error (fe_a),
    .overrun_error (oe_a),
    .busy          (busy_a)
  );

  rx_sequencer #(.BIT_PERIOD(16), .NUM_BITS(9)) u_dut_b (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_sync   (serial_b),
    .stop_bit      (sr_b[8]),
    .data_read     (data_read),
    .shift_strobe  (strobe_b),
    .load_buffer   (load_b),
    .data_ready    (ready_b),
    .framing_error (fe_b),
    .overrun_error (oe_b),
    .busy          (busy_b)
  );

  // Drive one frame (or a glitch of low_len cycles, if nonzero) on the selected
  // line and record outputs. rst_at pulses n_rst low in that cycle and forces the
  // line high from then on; read_at pulses data_read. Use -1 to disable either.
  task automatic run_frame(input int sel, input logic [7:0] data, input logic stop,
                           input int bp, input int ncyc, input int low_len,
                           input int rst_at, input int read_at);
    logic [9:0] fb;
    logic ln;
    int j;
    fb = {stop, data, 1'b0};
    n_loads = 0;
    n_strobes = 0;
    obs_pkt = '0;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      j = t / bp;
      if (low_len > 0) ln = (t >= low_len);
      else if (rst_at >= 0 && t >= rst_at) ln = 1'b1;
      else if (j < 10) ln = fb[j];
      else ln = 1'b1;
      if (sel == 0) serial_a = ln;
      else serial_b = ln;
      n_rst = (t != rst_at);
      data_read = (t == read_at);
      #1;
      if (sel == 0) begin
        obs_strobe[t] = strobe_a; obs_load[t] = load_a; obs_ready[t] = ready_a;
        obs_fe[t] = fe_a; obs_oe[t] = oe_a; obs_busy[t] = busy_a;
        if (load_a) obs_pkt = sr_a[7:0];
      end else begin
        obs_strobe[t] = strobe_b; obs_load[t] = load_b; obs_ready[t] = ready_b;
        obs_fe[t] = fe_b; obs_oe[t] = oe_b; obs_busy[t] = busy_b;
        if (load_b) obs_pkt = sr_b[7:0];
      end
      if (obs_load[t] === 1'b1) n_loads++;
      if (obs_strobe[t] === 1'b1) n_strobes++;
    end
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      serial_a = 1'b1;
      serial_b = 1'b1;
      data_read = 1'b0;
      n_rst = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_vec++;
    if ({strobe_a, load_a, ready_a, fe_a, oe_a, busy_a} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_a: got %b want 000000",
               {strobe_a, load_a, ready_a, fe_a, oe_a, busy_a});
    end
    n_vec++;
    if ({strobe_b, load_b, ready_b, fe_b, oe_b, busy_b} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_b: got %b want 000000",
               {strobe_b, load_b, ready_b, fe_b, oe_b, busy_b});
    end
    idle(4);
  endtask

  task automatic test_good_frame();
    logic es, el;
    run_frame(0, 8'hA5, 1'b1, 10, 110, 0, -1, -1);
    for (int t = 0; t < 110; t++) begin
      es = (t >= 15 && t <= 95 && (t - 15) % 10 == 0);
      el = (t == 96);
      n_vec++;
      if (obs_strobe[t] !== es || obs_load[t] !== el) begin
        n_err++;
        $display("FAIL good_timing t=%0d: strobe/load got %b%b want %b%b",
                 t, obs_strobe[t], obs_load[t], es, el);
      end
    end
    n_vec++;
    if (obs_pkt !== 8'hA5) begin
      n_err++; $display("FAIL good_pkt: got %h want a5", obs_pkt);
    end
    n_vec++;
    if ({obs_ready[96], obs_ready[97], obs_fe[97], obs_busy[96], obs_busy[97]} !== 5'b01010)
    begin
      n_err++;
      $display("FAIL good_flags: rdy96 rdy97 fe97 busy96 busy97 got %b want 01010",
               {obs_ready[96], obs_ready[97], obs_fe[97], obs_busy[96], obs_busy[97]});
    end
    @(negedge clk); data_read = 1'b1;
    @(negedge clk); data_read = 1'b0; #1;
    n_vec++;
    if (ready_a !== 1'b0) begin
      n_err++; $display("FAIL good_read_clear: data_ready got %b want 0", ready_a);
    end
    idle(2);
  endtask

  task automatic test_framing();
    run_frame(0, 8'hA5, 1'b0, 10, 110, 0, -1, -1);
    n_vec++;
    if (n_loads != 0 || n_strobes != 9) begin
      n_err++;
      $display("FAIL bad_counts: loads=%0d strobes=%0d want 0 and 9", n_loads, n_strobes);
    end
    n_vec++;
    if ({obs_fe[96], obs_fe[97], obs_ready[109]} !== 3'b010) begin
      n_err++;
      $display("FAIL bad_flags: fe96 fe97 rdy got %b want 010",
               {obs_fe[96], obs_fe[97], obs_ready[109]});
    end
    idle(2);
    run_frame(0, 8'h3E, 1'b1, 10, 110, 0, -1, -1);
    n_vec++;
    if ({obs_fe[0], obs_fe[1]} !== 2'b10) begin
      n_err++;
      $display("FAIL fe_clear: fe at E,E+1 got %b want 10", {obs_fe[0], obs_fe[1]});
    end
    n_vec++;
    if (n_loads != 1 || obs_pkt !== 8'h3E || obs_ready[97] !== 1'b1) begin
      n_err++;
      $display("FAIL fe_clear_frame: loads=%0d pkt=%h rdy=%b want 1 3e 1",
               n_loads, obs_pkt, obs_ready[97]);
    end
    idle(2);
  endtask

  task automatic test_glitch();
    // Buffer still holds the 0x3E byte; the glitch must leave it and the flags alone.
    run_frame(0, 8'h00, 1'b1, 10, 30, 3, -1, -1);
    n_vec++;
    if (n_strobes != 0) begin
      n_err++; $display("FAIL glitch_strobes: got %0d want 0", n_strobes);
    end
    n_vec++;
    if ({obs_busy[1], obs_busy[5], obs_busy[6]} !== 3'b110) begin
      n_err++;
      $display("FAIL glitch_busy: busy E+1,E+5,E+6 got %b want 110",
               {obs_busy[1], obs_busy[5], obs_busy[6]});
    end
    n_vec++;
    if ({obs_fe[29], obs_ready[29], obs_oe[29]} !== 3'b010) begin
      n_err++;
      $display("FAIL glitch_flags: fe rdy oe got %b want 010",
               {obs_fe[29], obs_ready[29], obs_oe[29]});
    end
    @(negedge clk); data_read = 1'b1;
    @(negedge clk); data_read = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 8'h5A, 1'b1, 10, 97, 0, -1, -1);
    n_vec++;
    if (obs_load[96] !== 1'b1 || obs_pkt !== 8'h5A || obs_oe[96] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: load=%b pkt=%h oe=%b want 1 5a 0",
               obs_load[96], obs_pkt, obs_oe[96]);
    end
    run_frame(0, 8'h96, 1'b1, 10, 110, 0, -1, -1);
    n_vec++;
    if ({obs_ready[0], obs_oe[0], obs_busy[1]} !== 3'b101) begin
      n_err++;
      $display("FAIL b2b_edge: rdy oe busy(E+1) got %b want 101",
               {obs_ready[0], obs_oe[0], obs_busy[1]});
    end
    n_vec++;
    if ({obs_load[96], obs_oe[96], obs_oe[97], obs_ready[97]} !== 4'b1011) begin
      n_err++;
      $display("FAIL b2b_overrun: load96 oe96 oe97 rdy97 got %b want 1011",
               {obs_load[96], obs_oe[96], obs_oe[97], obs_ready[97]});
    end
    n_vec++;
    if (obs_pkt !== 8'h96) begin
      n_err++; $display("FAIL b2b_pkt: got %h want 96", obs_pkt);
    end
    @(negedge clk); data_read = 1'b1; #1;
    n_vec++;
    if ({ready_a, oe_a} !== 2'b11) begin
      n_err++; $display("FAIL b2b_read_cycle: rdy oe got %b want 11", {ready_a, oe_a});
    end
    @(negedge clk); data_read = 1'b0; #1;
    n_vec++;
    if ({ready_a, oe_a} !== 2'b00) begin
      n_err++; $display("FAIL b2b_read_after: rdy oe got %b want 00", {ready_a, oe_a});
    end
    idle(2);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(0, 8'h0F, 1'b1, 10, 110, 0, -1, -1);
    run_frame(0, 8'hF0, 1'b1, 10, 110, 0, 40, -1);
    n_vec++;
    if ({obs_ready[39], obs_busy[39]} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_before: rdy busy got %b want 11", {obs_ready[39], obs_busy[39]});
    end
    n_vec++;
    if ({obs_strobe[40], obs_load[40], obs_ready[40], obs_fe[40], obs_oe[40], obs_busy[40]}
        !== 6'b0) begin
      n_err++;
      $display("FAIL rst_async: outputs got %b want 000000",
               {obs_strobe[40], obs_load[40], obs_ready[40], obs_fe[40], obs_oe[40],
                obs_busy[40]});
    end
    for (int t = 41; t < 110; t++) begin
      n_vec++;
      if ({obs_strobe[t], obs_load[t], obs_busy[t]} !== 3'b000) begin
        n_err++;
        $display("FAIL rst_quiet t=%0d: strobe load busy got %b want 000",
                 t, {obs_strobe[t], obs_load[t], obs_busy[t]});
      end
    end
    idle(2);
    run_frame(0, 8'hC3, 1'b1, 10, 110, 0, -1, -1);
    n_vec++;
    if (n_strobes != 9 || obs_load[96] !== 1'b1 || obs_pkt !== 8'hC3 || obs_ready[97] !== 1'b1)
    begin
      n_err++;
      $display("FAIL rst_fresh: strobes=%0d load=%b pkt=%h rdy=%b want 9 1 c3 1",
               n_strobes, obs_load[96], obs_pkt, obs_ready[97]);
    end
    @(negedge clk); data_read = 1'b1;
    @(negedge clk); data_read = 1'b0;
    idle(2);
  endtask

  task automatic test_bit_period_16();
    logic es, el;
    run_frame(1, 8'h3C, 1'b1, 16, 154, 0, -1, -1);
    for (int t = 0; t < 154; t++) begin
      es = (t >= 24 && t <= 152 && (t - 24) % 16 == 0);
      el = (t == 153);
      n_vec++;
      if (obs_strobe[t] !== es || obs_load[t] !== el) begin
        n_err++;
        $display("FAIL bp16_timing t=%0d: strobe/load got %b%b want %b%b",
                 t, obs_strobe[t], obs_load[t], es, el);
      end
    end
    n_vec++;
    if (obs_pkt !== 8'h3C) begin
      n_err++; $display("FAIL bp16_pkt: got %h want 3c", obs_pkt);
    end
    run_frame(1, 8'h81, 1'b1, 16, 170, 0, -1, -1);
    n_vec++;
    if ({obs_ready[0], obs_busy[0], obs_busy[1]} !== 3'b101) begin
      n_err++;
      $display("FAIL bp16_next_edge: rdy busy(E) busy(E+1) got %b want 101",
               {obs_ready[0], obs_busy[0], obs_busy[1]});
    end
    n_vec++;
    if (obs_load[153] !== 1'b1 || obs_pkt !== 8'h81 || obs_oe[154] !== 1'b1) begin
      n_err++;
      $display("FAIL bp16_second: load=%b pkt=%h oe=%b want 1 81 1",
               obs_load[153], obs_pkt, obs_oe[154]);
    end
    idle(2);
  endtask

  initial begin
    n_rst = 1'b0;
    data_read = 1'b0;
    serial_a = 1'b1;
    serial_b = 1'b1;
    test_reset();
    test_good_frame();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_bit_period_16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
